// File: rtl/pcie_sup_pkg.sv
// Shared state encoding and lane-width helper for the PCIe link supervisor.
package pcie_sup_pkg;

   localparam logic [1:0] ST_RESET_HOLD = 2'd0;
   localparam logic [1:0] ST_WAIT_LINK  = 2'd1;
   localparam logic [1:0] ST_LINK_UP    = 2'd2;
   localparam logic [1:0] ST_FAILED     = 2'd3;

   typedef enum logic [1:0] {
      RESET_HOLD = ST_RESET_HOLD,
      WAIT_LINK  = ST_WAIT_LINK,
      LINK_UP    = ST_LINK_UP,
      FAILED     = ST_FAILED
   } state_t;

   // True when the negotiated width covers every wired lane.
   function automatic logic lanes_ok(input logic [3:0] neg_width, input int unsigned max_lanes);
      return 32'(neg_width) >= max_lanes;
   endfunction

endpackage

// File: rtl/sup_debounce.sv
// Stable-level counter: pulses stable_c on the DEBOUNCE-th consecutive cycle
// that level equals polarity while enabled.
module sup_debounce
   import pcie_sup_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic level,
   input  logic polarity,
   output logic stable_c
);

   localparam int unsigned CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

   logic [CW-1:0] cnt;
   logic          match;

   assign match    = enable && (level == polarity);
   assign stable_c = match && (cnt == CW'(DEBOUNCE - 1));

   // Counter restarts on any mismatch, on completion, or when the owner clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear || !match || stable_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/pcie_link_supervisor.sv
// PCIe endpoint reset/link supervisor: timed core reset, link-up wait with
// bounded retries, debounced drop detection and link health reporting.
module pcie_link_supervisor
   import pcie_sup_pkg::*;
#(
   parameter int unsigned MAX_LANES       = 4,
   parameter int unsigned RST_HOLD_CYCLES = 1024,
   parameter int unsigned LINK_TIMEOUT    = 1_000_000,
   parameter int unsigned DEBOUNCE        = 16,
   parameter int unsigned MAX_RETRIES     = 3,
   parameter int unsigned CNT_W           = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               lnk_up,
   input  logic [3:0]                         neg_width,
   input  logic                               retrain_req,
   output logic                               core_rst,
   output logic                               link_ok,
   output logic                               link_failed,
   output logic                               width_degraded,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
   output logic [CNT_W-1:0]                   drop_cnt,
   output logic [1:0]                         state_o
);

   localparam int unsigned RW   = $clog2(MAX_RETRIES + 1);
   localparam int unsigned TMAX = (RST_HOLD_CYCLES > LINK_TIMEOUT) ? RST_HOLD_CYCLES : LINK_TIMEOUT;
   localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

   state_t           state, state_next;
   logic [TW-1:0]    timer, timer_next;
   logic [RW-1:0]    retry_next;
   logic [CNT_W-1:0] drop_next;
   logic             deb_stable_c;
   logic             deb_clear_c;
   logic             deb_enable_c;
   logic             deb_polarity_c;

   // WAIT_LINK looks for a stable high, LINK_UP for a stable low.
   assign deb_enable_c   = (state == WAIT_LINK) || (state == LINK_UP);
   assign deb_polarity_c = (state == WAIT_LINK);
   assign deb_clear_c    = retrain_req || (state_next != state);

   sup_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .clear    (deb_clear_c),
      .enable   (deb_enable_c),
      .level    (lnk_up),
      .polarity (deb_polarity_c),
      .stable_c (deb_stable_c)
   );

   // Next-state, timer and counter updates.
   always_comb begin
      state_next = state;
      timer_next = timer;
      retry_next = retry_cnt;
      drop_next  = drop_cnt;
      if (retrain_req) begin
         state_next = RESET_HOLD;
         timer_next = '0;
         retry_next = '0;
      end else begin
         case (state)
            RESET_HOLD: begin
               if (timer == TW'(RST_HOLD_CYCLES - 1)) begin
                  state_next = WAIT_LINK;
                  timer_next = '0;
               end else begin
                  timer_next = timer + TW'(1);
               end
            end
            WAIT_LINK: begin
               // A link that becomes stable on the timeout cycle still wins.
               if (deb_stable_c) begin
                  state_next = LINK_UP;
                  timer_next = '0;
                  retry_next = '0;
               end else if (timer == TW'(LINK_TIMEOUT - 1)) begin
                  timer_next = '0;
                  if (retry_cnt < RW'(MAX_RETRIES)) begin
                     retry_next = retry_cnt + RW'(1);
                     state_next = RESET_HOLD;
                  end else begin
                     state_next = FAILED;
                  end
               end else begin
                  timer_next = timer + TW'(1);
               end
            end
            LINK_UP: begin
               timer_next = '0;
               retry_next = '0;
               if (deb_stable_c) begin
                  state_next = RESET_HOLD;
                  if (drop_cnt != '1) begin
                     drop_next = drop_cnt + CNT_W'(1);
                  end
               end
            end
            FAILED: begin
               timer_next = '0;
            end
            default: begin
               state_next = RESET_HOLD;
               timer_next = '0;
            end
         endcase
      end
   end

   // State, counters and next-state-decoded outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= RESET_HOLD;
         timer          <= '0;
         retry_cnt      <= '0;
         drop_cnt       <= '0;
         core_rst       <= 1'b1;
         link_ok        <= 1'b0;
         link_failed    <= 1'b0;
         width_degraded <= 1'b0;
      end else begin
         state          <= state_next;
         timer          <= timer_next;
         retry_cnt      <= retry_next;
         drop_cnt       <= drop_next;
         core_rst       <= (state_next == RESET_HOLD);
         link_ok        <= (state_next == LINK_UP);
         link_failed    <= (state_next == FAILED);
         width_degraded <= (state_next == LINK_UP) && !lanes_ok(neg_width, MAX_LANES);
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pcie_link_supervisor.sv
// Scoreboard bench for pcie_link_supervisor: a cycle model queues expected
// outputs as stimulus is driven; each is popped and compared after the edge.
module tb_pcie_link_supervisor;

   localparam int unsigned MAX_LANES = 4;
   localparam int unsigned RST_HOLD  = 8;
   localparam int unsigned TIMEOUT   = 20;
   localparam int unsigned DEB       = 3;
   localparam int unsigned MAXR      = 2;
   localparam int unsigned CNT_W     = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       lnk_up;
   logic [3:0] neg_width;
   logic       retrain_req;
   logic       core_rst;
   logic       link_ok;
   logic       link_failed;
   logic       width_degraded;
   logic [1:0] retry_cnt;
   logic [7:0] drop_cnt;
   logic [1:0] state_o;

   always #5 clk = ~clk;

   pcie_link_supervisor #(
      .MAX_LANES       (MAX_LANES),
      .RST_HOLD_CYCLES (RST_HOLD),
      .LINK_TIMEOUT    (TIMEOUT),
      .DEBOUNCE        (DEB),
      .MAX_RETRIES     (MAXR),
      .CNT_W           (CNT_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .lnk_up         (lnk_up),
      .neg_width      (neg_width),
      .retrain_req    (retrain_req),
      .core_rst       (core_rst),
      .link_ok        (link_ok),
      .link_failed    (link_failed),
      .width_degraded (width_degraded),
      .retry_cnt      (retry_cnt),
      .drop_cnt       (drop_cnt),
      .state_o        (state_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] sb[$];

   int   m_state, m_timer, m_run, m_retry, m_drop;
   logic m_wd;

   function automatic logic [15:0] pack(input int st, input logic rst, input logic ok,
                                        input logic fail, input logic wd,
                                        input int retry, input int drop);
      return {2'(st), rst, ok, fail, wd, 2'(retry), 8'(drop)};
   endfunction

   function automatic logic [15:0] obs();
      return {state_o, core_rst, link_ok, link_failed, width_degraded, retry_cnt, drop_cnt};
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
   endtask

   task automatic model_reset();
      m_state = 0; m_timer = 0; m_run = 0; m_retry = 0; m_drop = 0; m_wd = 1'b0;
   endtask

   // Behavioural reference: timer counts elapsed cycles in the current state.
   task automatic model_step(input logic lnk, input logic [3:0] w, input logic rr);
      int ns;
      ns = m_state;
      if (rr) begin
         ns = 0; m_timer = 0; m_retry = 0;
      end else begin
         case (m_state)
            0: begin
               m_timer++;
               if (m_timer == int'(RST_HOLD)) ns = 1;
            end
            1: begin
               m_timer++;
               m_run = lnk ? m_run + 1 : 0;
               if (m_run == int'(DEB)) begin
                  ns = 2; m_retry = 0;
               end else if (m_timer == int'(TIMEOUT)) begin
                  if (m_retry < int'(MAXR)) begin
                     m_retry++; ns = 0;
                  end else begin
                     ns = 3;
                  end
               end
            end
            2: begin
               m_run = lnk ? 0 : m_run + 1;
               if (m_run == int'(DEB)) begin
                  ns = 0;
                  if (m_drop < 255) m_drop++;
               end
            end
            default: ;
         endcase
      end
      if (ns != m_state || rr) begin
         m_run = 0; m_timer = 0;
      end
      m_wd    = (ns == 2) && (int'(w) < int'(MAX_LANES));
      m_state = ns;
      sb.push_back(pack(m_state, m_state == 0, m_state == 2, m_state == 3, m_wd, m_retry, m_drop));
   endtask

   task automatic tick(input logic lnk, input logic [3:0] w, input logic rr);
      lnk_up = lnk; neg_width = w; retrain_req = rr;
      model_step(lnk, w, rr);
      @(posedge clk); #1;
      check("cycle", obs(), sb.pop_front());
   endtask

   task automatic run(input int n, input logic lnk, input logic [3:0] w);
      for (int i = 0; i < n; i++) tick(lnk, w, 1'b0);
   endtask

   initial begin
      reset = 1'b1; lnk_up = 1'b0; neg_width = 4'd4; retrain_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", obs(), pack(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
      @(negedge clk);
      reset = 1'b0;

      // Bring-up: lnk_up rises at cycle 12, link_ok after cycle 14.
      run(12, 1'b0, 4'd4);
      run(3, 1'b1, 4'd4);
      check("link_ok_c14", 16'(link_ok), 16'd1);
      check("wd_full_width", 16'(width_degraded), 16'd0);
      run(4, 1'b1, 4'd4);

      // Short glitch ignored, full-length drop retrains.
      run(2, 1'b0, 4'd4);
      run(2, 1'b1, 4'd4);
      check("glitch_ignored", 16'(state_o), 16'd2);
      run(3, 1'b0, 4'd4);
      check("drop_count_1", 16'(drop_cnt), 16'd1);
      check("drop_core_rst", 16'(core_rst), 16'd1);

      // Degraded width on entry, cleared when width recovers.
      run(8, 1'b0, 4'd2);
      run(3, 1'b1, 4'd2);
      check("wd_set", 16'(width_degraded), 16'd1);
      tick(1'b1, 4'd4, 1'b0);
      check("wd_clear", 16'(width_degraded), 16'd0);

      // Exhaust retries into FAILED, then retrain out of it.
      tick(1'b1, 4'd4, 1'b1);
      run(3 * (RST_HOLD + TIMEOUT), 1'b0, 4'd4);
      check("failed_state", {state_o, core_rst, link_failed}, 16'b1101);
      check("failed_retry", 16'(retry_cnt), 16'd2);
      run(5, 1'b1, 4'd4);
      check("failed_sticky", 16'(state_o), 16'd3);
      tick(1'b0, 4'd4, 1'b1);
      check("retrain_exit", {state_o, retry_cnt, core_rst}, 16'b00001);

      // Debounce completes on the timeout cycle.
      run(RST_HOLD, 1'b0, 4'd4);
      run(TIMEOUT - DEB, 1'b0, 4'd4);
      run(DEB, 1'b1, 4'd4);
      check("deb_beats_timeout", 16'(link_ok), 16'd1);

      // Retrain on the same cycle as a debounced drop.
      run(DEB - 1, 1'b0, 4'd4);
      tick(1'b0, 4'd4, 1'b1);
      check("retrain_no_drop", {state_o, drop_cnt}, {2'd0, 8'd1});

      // Saturate the drop counter.
      for (int k = 0; k < (1 << CNT_W) + 2; k++) begin
         run(RST_HOLD, 1'b0, 4'd4);
         run(DEB, 1'b1, 4'd4);
         run(DEB, 1'b0, 4'd4);
      end
      check("drop_saturate", 16'(drop_cnt), 16'd255);

      // Asynchronous reset while waiting for link.
      run(RST_HOLD + 2, 1'b0, 4'd4);
      check("in_wait_link", 16'(state_o), 16'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset", obs(), pack(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      run(RST_HOLD + 4, 1'b0, 4'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
